afifo_wptr_full: RTL and testbench
==================================

Name: afifo_wptr_full

Overview:
- Write-domain control half of the async FIFO.
- Owns the binary and Gray write pointers, accepts writes via a valid/ready handshake, and drives the dual-port RAM write enable and address.
- Publishes the registered Gray write pointer, which is carried into the read domain through a per-bit synchronizer bank.
- Consumes the already-synchronized Gray read pointer and derives full, almost-full and fill level from it.

Parameters:
- C_ADDR_W, 4, RAM address width; FIFO depth = 2**C_ADDR_W. Legal range is 2 or more.
- C_AFULL_THRESH, 2**C_ADDR_W - 2, fill level at or above which o_afull asserts. Legal range is 1..2**C_ADDR_W.

Ports:
- i_clk  in  1  write-domain clock.
- i_rst  in  1  reset; synchronous to i_clk, active-high.
- i_valid  in  1  writer has a word to push.
- o_ready  out  1  block can accept a word this cycle.
- o_wr_en  out  1  RAM write strobe; equals i_valid & o_ready (combinational).
- o_wr_addr  out  C_ADDR_W  RAM write address = wbin[C_ADDR_W-1:0].
- o_wgray  out  C_ADDR_W+1  registered Gray write pointer, sent to the read-domain synchronizers.
- i_rgray_sync  in  C_ADDR_W+1  Gray read pointer, already synchronized into i_clk.
- o_full  out  1  FIFO full (registered).
- o_afull  out  1  level >= C_AFULL_THRESH (registered).
- o_level  out  C_ADDR_W+1  conservative fill count (registered), range 0..2**C_ADDR_W.

Behaviour:
- State: wbin and wgray, each C_ADDR_W+1 bits; the extra MSB is the wrap bit.
- push = i_valid & o_ready. When i_valid=1 and o_ready=0 the request is ignored; nothing changes.
- Next-pointer values:
  - wbin_n = wbin + push, modulo 2**(C_ADDR_W+1).
  - wgray_n = (wbin_n >> 1) ^ wbin_n.
- Registered updates each clock:
  - wbin <= wbin_n; wgray <= wgray_n.
  - full <= (wgray_n == {~i_rgray_sync[C_ADDR_W:C_ADDR_W-1], i_rgray_sync[C_ADDR_W-2:0]}).
  - o_level <= wbin_n - gray2bin(i_rgray_sync), modulo 2**(C_ADDR_W+1).
  - o_afull <= (level_n >= C_AFULL_THRESH).
  - o_ready <= ~full_n.
- Latency:
  - A push is visible on o_wgray, o_full, o_afull and o_level 1 cycle later.
  - A change on i_rgray_sync is reflected 1 cycle later.
- Conservatism:
  - The synchronized read pointer is stale, so full and level can only over-report. They must never under-report.
  - o_full deasserts only after i_rgray_sync advances.
- Simultaneous push and read-pointer advance in the same cycle: use wgray_n together with the current i_rgray_sync. Net level is unchanged.
- Wrap-around: wbin wraps from 2**(C_ADDR_W+1)-1 to 0; o_wr_addr wraps from 2**C_ADDR_W-1 to 0. No special casing.
- o_wgray is driven only from a flop (no combinational path) so it is glitch-free for the synchronizers.
- Reset (i_rst=1, any cycle, including mid-operation):
  - Next edge: wbin=0, wgray=0, o_full=0, o_afull=0, o_level=0, o_ready=0.
  - o_wr_en is forced to 0 while i_rst=1.
  - o_ready goes to 1 on the first edge after i_rst falls.
  - The read side must be reset in the same system reset window; this block does not detect pointer mismatch.
- i_rgray_sync is never decoded as anything other than a Gray pointer; a non-Gray input is a system error and is not checked.

Decomposition:
- Package afifo_pkg contains:
  - functions bin2gray and gray2bin, parameterized by width through a localparam-sized argument;
  - a constant for the default address width.
  - The read-side mirror block (afifo_rptr_empty) reuses the same package.
- No sub-module; pointer logic is flat. Synchronizer instances live in the FIFO top, not here.

Test Plan (C_ADDR_W=3, C_AFULL_THRESH=6):
- Reset: hold i_rst 2 cycles, then release → o_wgray=0, o_level=0, o_full=0, o_afull=0; o_ready=1 on the first cycle after release.
- Fill: i_rgray_sync=0, i_valid=1 for 10 cycles →
  - o_wr_addr steps 0..7; o_wgray steps 1,3,2,6,7,5,4,12;
  - o_afull rises after the 6th push; o_full=1 and o_ready=0 after the 8th push;
  - o_level=8; exactly 8 o_wr_en pulses.
- Full hold: keep i_valid=1 for 5 more cycles → no o_wr_en; o_wgray stays 12.
- Drain: set i_rgray_sync=1 (read bin 1) → next cycle o_full=0, o_ready=1, o_level=7, o_afull=1.
- Wrap: 20 cycles of push with i_rgray_sync tracking gray(wbin-2) → o_level constant 2, o_full never set, o_wr_addr wraps 7→0, wbin wraps 15→0.
- Mid-op reset: at o_level=5, assert i_rst with i_valid=1 → o_wr_en=0 during reset; all outputs 0 after the next edge.

Source files
------------

// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO pointer blocks (write and read halves).
// Gray/binary conversions run at a fixed maximum width; callers zero-extend and slice.
package afifo_pkg;

  localparam int C_DEF_ADDR_W = 4;
  localparam int C_PTR_MAX_W  = 32;

  typedef logic [C_PTR_MAX_W-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin[C_PTR_MAX_W-1] = gray[C_PTR_MAX_W-1];
    for (int i = C_PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/afifo_wptr_full.sv
// Write-domain pointer and full/almost-full/level tracking for the async FIFO.
// Handshake: a word is pushed on any cycle where i_valid and o_ready are both high.
module afifo_wptr_full
  import afifo_pkg::*;
#(
  parameter int C_ADDR_W       = C_DEF_ADDR_W,
  parameter int C_AFULL_THRESH = 2**C_ADDR_W - 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  output logic                o_wr_en,
  output logic [C_ADDR_W-1:0] o_wr_addr,
  output logic [C_ADDR_W:0]   o_wgray,
  input  logic [C_ADDR_W:0]   i_rgray_sync,
  output logic                o_full,
  output logic                o_afull,
  output logic [C_ADDR_W:0]   o_level
);

  localparam int C_PTR_W = C_ADDR_W + 1;
  localparam logic [C_PTR_W-1:0] C_THRESH = C_PTR_W'(C_AFULL_THRESH);

  logic [C_PTR_W-1:0] wbin_q,  wbin_d;
  logic [C_PTR_W-1:0] wgray_q, wgray_d;
  logic [C_PTR_W-1:0] level_q, level_d;
  logic               full_q,  full_d;
  logic               afull_q, afull_d;
  logic               ready_q, ready_d;

  logic               push;
  logic [C_PTR_W-1:0] full_cmp;
  ptr_max_t           wbin_ext;
  ptr_max_t           wgray_ext;
  ptr_max_t           rbin_ext;

  // Reset gates the strobe so a pending request can never write during reset.
  assign push = i_valid & ready_q & ~i_rst;

  // Full when the write pointer is one lap ahead of the read pointer, in Gray form.
  assign full_cmp = {~i_rgray_sync[C_ADDR_W:C_ADDR_W-1], i_rgray_sync[C_ADDR_W-2:0]};

  always_comb begin
    wbin_d    = wbin_q + {{C_ADDR_W{1'b0}}, push};
    wbin_ext  = {{(C_PTR_MAX_W-C_PTR_W){1'b0}}, wbin_d};
    wgray_ext = bin2gray(wbin_ext);
    rbin_ext  = gray2bin({{(C_PTR_MAX_W-C_PTR_W){1'b0}}, i_rgray_sync});
    wgray_d   = wgray_ext[C_PTR_W-1:0];
    level_d   = wbin_d - rbin_ext[C_PTR_W-1:0];
    full_d    = (wgray_d == full_cmp);
    afull_d   = (level_d >= C_THRESH);
    ready_d   = ~full_d;
    if (i_rst) begin
      wbin_d  = '0;
      wgray_d = '0;
      level_d = '0;
      full_d  = 1'b0;
      afull_d = 1'b0;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    wbin_q  <= wbin_d;
    wgray_q <= wgray_d;
    level_q <= level_d;
    full_q  <= full_d;
    afull_q <= afull_d;
    ready_q <= ready_d;
  end

  assign o_ready   = ready_q;
  assign o_wr_en   = push;
  assign o_wr_addr = wbin_q[C_ADDR_W-1:0];
  assign o_wgray   = wgray_q;
  assign o_full    = full_q;
  assign o_afull   = afull_q;
  assign o_level   = level_q;

endmodule

// File: tb/tb_afifo_wptr_full.sv
// Directed plus randomized check of afifo_wptr_full against a counting model of the FIFO.
module tb_afifo_wptr_full;

  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [AW:0]   i_rgray_sync = '0;
  logic          o_ready, o_wr_en, o_full, o_afull;
  logic [AW-1:0] o_wr_addr;
  logic [AW:0]   o_wgray, o_level;

  int tests = 0;
  int failed = 0;

  // Model: absolute counts of words written and read.
  int m_w = 0, m_r = 0, m_level = 0, pushes = 0;
  logic m_ready = 1'b0, m_full = 1'b0, m_afull = 1'b0;
  logic exp_push;

  logic [AW:0] exp_gray_seq [8];

  always #5 clk = ~clk;

  afifo_wptr_full #(.C_ADDR_W(AW), .C_AFULL_THRESH(6)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wgray(o_wgray),
    .i_rgray_sync(i_rgray_sync), .o_full(o_full), .o_afull(o_afull),
    .o_level(o_level)
  );

  function automatic logic [AW:0] gray(input int n);
    logic [AW:0] b;
    b = AW'(0) + (AW+1)'(n % 16);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic r, input int rd);
    @(negedge clk);
    i_valid = v;
    i_rst = r;
    m_r = rd;
    i_rgray_sync = gray(rd);
    #1;
    exp_push = v && m_ready && !r;
    check("wr_en", {31'd0, o_wr_en}, {31'd0, exp_push});
    if (!r) check("wr_addr", {29'd0, o_wr_addr}, 32'(m_w % DEPTH));
    @(posedge clk);
    if (r) begin
      m_w = 0; m_level = 0; m_full = 0; m_afull = 0; m_ready = 0;
    end else begin
      if (exp_push) begin
        m_w++;
        pushes++;
      end
      m_level = (m_w - m_r) % 16;
      m_full  = (m_level == DEPTH);
      m_afull = (m_level >= 6);
      m_ready = !m_full;
    end
    #1;
    check("wgray", {28'd0, o_wgray}, {28'd0, gray(m_w)});
    check("level", {28'd0, o_level}, 32'(m_level));
    check("full",  {31'd0, o_full},  {31'd0, m_full});
    check("afull", {31'd0, o_afull}, {31'd0, m_afull});
    check("ready", {31'd0, o_ready}, {31'd0, m_ready});
  endtask

  initial begin
    exp_gray_seq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};

    // Reset held two cycles, then released.
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 0);
    check("ready_after_rst", {31'd0, o_ready}, 32'd1);

    // Fill from empty with the reader parked at zero.
    pushes = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 0);
      if (i < 8) check("fill_gray", {28'd0, o_wgray}, {28'd0, exp_gray_seq[i]});
      if (i == 4) check("afull_pre", {31'd0, o_afull}, 32'd0);
      if (i == 5) check("afull_rise", {31'd0, o_afull}, 32'd1);
    end
    check("fill_pushes", 32'(pushes), 32'd8);
    check("fill_level", {28'd0, o_level}, 32'd8);
    check("fill_full", {31'd0, o_full}, 32'd1);

    // Full hold: requests ignored.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0);
    check("hold_pushes", 32'(pushes), 32'd8);
    check("hold_gray", {28'd0, o_wgray}, 32'd12);

    // One word drained.
    step(1'b0, 1'b0, 1);
    check("drain_level", {28'd0, o_level}, 32'd7);
    check("drain_full", {31'd0, o_full}, 32'd0);
    check("drain_afull", {31'd0, o_afull}, 32'd1);

    // Wrap: reader tracks two behind the written pointer.
    step(1'b0, 1'b0, m_w - 2);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, m_w - 1);
      check("wrap_level", {28'd0, o_level}, 32'd2);
    end

    // Random pushes and read advances.
    for (int i = 0; i < 300; i++) begin
      int rd;
      rd = m_r;
      if (rd < m_w && $urandom_range(0, 2) != 0) rd++;
      step(1'($urandom_range(0, 1)), 1'b0, rd);
    end

    // Mid-operation reset at level 5.
    step(1'b0, 1'b0, m_w);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, m_r);
    check("pre_rst_level", {28'd0, o_level}, 32'd5);
    step(1'b1, 1'b1, m_r);
    check("rst_wgray", {28'd0, o_wgray}, 32'd0);
    check("rst_level", {28'd0, o_level}, 32'd0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
